mp_engine: RTL and testbench



---
 rtl/mp_engine_pkg.sv | 25 ++
 rtl/mp_addr_gen.sv | 96 +++++++++
 rtl/mp_engine.sv | 136 +++++++++++++
 tb/tb_mp_engine.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_engine_pkg.sv
// Shared definitions for the max-pool engine: data/address widths, shape field
// widths, the control-FSM state encoding and the decoder's layer/opcode codes.
package mp_engine_pkg;

    localparam int DW = 16;   // element width, signed fixed point
    localparam int AW = 27;   // word address width
    localparam int CW = 11;   // channel-count field width
    localparam int HW = 13;   // height/width field width

    // Layer-type and opcode codes shared with the command decoder.
    localparam logic [1:0] LAYER_FC = 2'd0;
    localparam logic [1:0] LAYER_CV = 2'd1;
    localparam logic [1:0] LAYER_MP = 2'd2;
    localparam logic [3:0] OP_MP    = 4'h3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_RD,
        ST_RW,
        ST_WR,
        ST_DONE
    } mp_state_e;

endpackage

// File: rtl/mp_addr_gen.sv
// Address generator for 2x2 stride-2 pooling: walks c/oh/ow with incremental
// pointers and presents the current window-element read address and output address.
module mp_addr_gen
    import mp_engine_pkg::*;
#(
    parameter int AW = mp_engine_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    input  logic          advance,
    input  logic [1:0]    k,
    input  logic [AW-1:0] ifaddr,
    input  logic [AW-1:0] ofaddr,
    input  logic [CW-1:0] num_c,
    input  logic [HW-1:0] num_h,
    input  logic [HW-1:0] num_w,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] wr_addr,
    output logic          last
);

    logic [CW-1:0] c_idx;
    logic [HW-2:0] oh_idx;
    logic [HW-2:0] ow_idx;
    logic [AW-1:0] row_ptr;   // address of (c, 2*oh, 0)
    logic [AW-1:0] win_ptr;   // address of (c, 2*oh, 2*ow)
    logic [AW-1:0] out_ptr;

    logic [AW-1:0] w_ext;
    logic [AW-1:0] next_row;
    logic [AW-1:0] next_plane;
    logic [CW-1:0] c_max;
    logic [HW-2:0] oh_max;
    logic [HW-2:0] ow_max;

    assign w_ext    = AW'(num_w);
    assign next_row = row_ptr + (w_ext << 1);
    // An odd height leaves one unread row at the bottom of every plane.
    assign next_plane = next_row + (num_h[0] ? w_ext : '0);

    assign c_max  = num_c - CW'(1);
    assign oh_max = num_h[HW-1:1] - (HW-1)'(1);
    assign ow_max = num_w[HW-1:1] - (HW-1)'(1);
    assign last   = (c_idx == c_max) && (oh_idx == oh_max) && (ow_idx == ow_max);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        rd_addr = win_ptr;
        case (k)
            2'd1:    rd_addr = win_ptr + AW'(1);
            2'd2:    rd_addr = win_ptr + w_ext;
            2'd3:    rd_addr = win_ptr + w_ext + AW'(1);
            default: rd_addr = win_ptr;
        endcase
    end

    assign wr_addr = out_ptr;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_idx   <= '0;
            oh_idx  <= '0;
            ow_idx  <= '0;
            row_ptr <= '0;
            win_ptr <= '0;
            out_ptr <= '0;
        end else if (restart) begin
            c_idx   <= '0;
            oh_idx  <= '0;
            ow_idx  <= '0;
            row_ptr <= ifaddr;
            win_ptr <= ifaddr;
            out_ptr <= ofaddr;
        end else if (advance) begin
            out_ptr <= out_ptr + AW'(1);
            if (ow_idx != ow_max) begin
                ow_idx  <= ow_idx + (HW-1)'(1);
                win_ptr <= win_ptr + AW'(2);
            end else if (oh_idx != oh_max) begin
                ow_idx  <= '0;
                oh_idx  <= oh_idx + (HW-1)'(1);
                row_ptr <= next_row;
                win_ptr <= next_row;
            end else begin
                ow_idx  <= '0;
                oh_idx  <= '0;
                c_idx   <= c_idx + CW'(1);
                row_ptr <= next_plane;
                win_ptr <= next_plane;
            end
        end
    end

endmodule

// File: rtl/mp_engine.sv
// Max-pool engine: samples a job on mp_rst, reads each 2x2 window one element at a
// time, writes the signed maximum, and pulses mp_done when the whole map is done.
module mp_engine
    import mp_engine_pkg::*;
#(
    parameter int DW = mp_engine_pkg::DW,
    parameter int AW = mp_engine_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mp_rst,
    input  logic [AW-1:0] mp_ifaddr,
    input  logic [AW-1:0] mp_ofaddr,
    input  logic [CW-1:0] mp_C,
    input  logic [HW-1:0] mp_H,
    input  logic [HW-1:0] mp_W,
    output logic          mp_done,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_ready,
    input  logic          rd_valid,
    input  logic [DW-1:0] rd_data,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic          wr_ready
);

    mp_state_e     state;
    mp_state_e     state_nxt;
    logic [AW-1:0] cfg_ifaddr;
    logic [AW-1:0] cfg_ofaddr;
    logic [CW-1:0] cfg_c;
    logic [HW-1:0] cfg_h;
    logic [HW-1:0] cfg_w;
    logic [1:0]    k;
    logic [DW-1:0] max_val;
    logic          drain;     // a read from an aborted job is still in flight
    logic          restart;
    logic          advance;
    logic          last;
    logic          degenerate;
    logic          rd_take;

    assign degenerate = (cfg_c == '0) || (cfg_h < HW'(2)) || (cfg_w < HW'(2));
    assign rd_take    = (state == ST_RW) && rd_valid;
    assign restart    = (state == ST_CHK);

    mp_addr_gen #(.AW(AW)) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .advance (advance),
        .k       (k),
        .ifaddr  (cfg_ifaddr),
        .ofaddr  (cfg_ofaddr),
        .num_c   (cfg_c),
        .num_h   (cfg_h),
        .num_w   (cfg_w),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .last    (last)
    );

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_CHK: begin
                if (degenerate)            state_nxt = ST_DONE;
                else if (!drain || rd_valid) state_nxt = ST_RD;
            end
            ST_RD:   if (rd_ready) state_nxt = ST_RW;
            ST_RW:   if (rd_valid) state_nxt = (k == 2'd3) ? ST_WR : ST_RD;
            ST_WR: begin
                if (wr_ready) begin
                    if (last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // A new command overrides everything, including a pending write.
        if (mp_rst) begin
            state_nxt = ST_CHK;
            advance   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cfg_ifaddr <= '0;
            cfg_ofaddr <= '0;
            cfg_c      <= '0;
            cfg_h      <= '0;
            cfg_w      <= '0;
            k          <= '0;
            max_val    <= '0;
            drain      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mp_rst) begin
                cfg_ifaddr <= mp_ifaddr;
                cfg_ofaddr <= mp_ofaddr;
                cfg_c      <= mp_C;
                cfg_h      <= mp_H;
                cfg_w      <= mp_W;
                // Accepted-now or accepted-earlier reads whose data has not come back.
                drain <= ((state == ST_RD) && rd_ready) ||
                         (((state == ST_RW) || drain) && !rd_valid);
            end else begin
                if (drain && rd_valid) drain <= 1'b0;
                if (state == ST_CHK) begin
                    k <= '0;
                end else if (rd_take) begin
                    k <= k + 2'd1;
                    if ((k == 2'd0) || ($signed(rd_data) > $signed(max_val)))
                        max_val <= rd_data;
                end
            end
        end
    end

    assign mp_done = (state == ST_DONE);
    assign rd_req  = (state == ST_RD);
    assign wr_req  = (state == ST_WR);
    assign wr_data = max_val;

endmodule

// File: tb/tb_mp_engine.sv
// Scoreboard bench for mp_engine: a memory responder serves reads, expected writes
// are queued by the stimulus and popped by the monitor as the engine writes.
module tb_mp_engine;

    localparam int DW = 16;
    localparam int AW = 27;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mp_rst;
    logic [AW-1:0] mp_ifaddr;
    logic [AW-1:0] mp_ofaddr;
    logic [10:0]   mp_C;
    logic [12:0]   mp_H;
    logic [12:0]   mp_W;
    logic          mp_done;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;

    always #5 clk = ~clk;

    mp_engine #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mp_rst    (mp_rst),
        .mp_ifaddr (mp_ifaddr),
        .mp_ofaddr (mp_ofaddr),
        .mp_C      (mp_C),
        .mp_H      (mp_H),
        .mp_W      (mp_W),
        .mp_done   (mp_done),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready)
    );

    typedef struct {
        logic [AW-1:0]        addr;
        logic signed [DW-1:0] data;
    } wr_exp_t;

    wr_exp_t              exp_q[$];
    logic signed [DW-1:0] mem [int];
    int  checks      = 0;
    int  errors      = 0;
    int  done_cnt    = 0;
    int  req_cycles  = 0;
    int  rd_acc      = 0;
    bit  bp          = 1'b0;
    int  fixed_delay = 0;
    logic mp_rst_q   = 1'b0;

    always @(posedge clk) mp_rst_q <= mp_rst;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic ld(input int a, input int v);
        mem[a] = 16'(v);
    endtask

    task automatic push(input int a, input int v);
        wr_exp_t e;
        e.addr = AW'(a);
        e.data = 16'(v);
        exp_q.push_back(e);
    endtask

    // Memory responder plus read/write/done monitors, all acting on the falling edge.
    initial begin : responder
        bit            pend;
        int            cnt;
        logic [AW-1:0] paddr;
        bit            rd_hold;
        bit            wr_hold;
        logic [AW-1:0] hold_raddr;
        logic [AW-1:0] hold_waddr;
        logic [DW-1:0] hold_wdata;
        wr_exp_t       e;
        pend = 0; cnt = 0; paddr = '0; rd_hold = 0; wr_hold = 0;
        hold_raddr = '0; hold_waddr = '0; hold_wdata = '0;
        rd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0; wr_ready = 1'b0;
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = mem.exists(int'(paddr)) ? mem[int'(paddr)] : 16'h7fff;
                    pend     = 0;
                end else begin
                    cnt--;
                end
            end
            if (rd_hold && !mp_rst_q) begin
                check("rd_req_held", longint'(rd_req), 1);
                check("rd_addr_held", longint'(rd_addr), longint'(hold_raddr));
            end
            if (wr_hold && !mp_rst_q) begin
                check("wr_req_held", longint'(wr_req), 1);
                check("wr_addr_held", longint'(wr_addr), longint'(hold_waddr));
                check("wr_data_held", longint'(wr_data), longint'(hold_wdata));
            end
            rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_req && rd_ready) begin
                rd_acc++;
                check("rd_one_outstanding", longint'(pend), 0);
                check("rd_addr_in_map", longint'(mem.exists(int'(rd_addr))), 1);
                pend  = 1;
                paddr = rd_addr;
                cnt   = bp ? int'($urandom_range(0, 5)) : fixed_delay;
            end
            rd_hold    = rd_req && !rd_ready;
            hold_raddr = rd_addr;
            if (wr_req && wr_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", longint'(wr_addr), longint'(e.addr));
                    check("wr_data", longint'($signed(wr_data)), longint'(e.data));
                end
            end
            wr_hold    = wr_req && !wr_ready;
            hold_waddr = wr_addr;
            hold_wdata = wr_data;
            if (rd_req || wr_req) req_cycles++;
            if (mp_done) begin
                done_cnt++;
                check("done_no_req", longint'(rd_req || wr_req), 0);
                check("done_after_writes", longint'(exp_q.size()), 0);
            end
        end
    end

    // Pulses mp_rst with a job and waits for mp_done; exp_lat > 0 also checks the
    // mp_rst-to-mp_done latency in clock edges (2 means no memory traffic allowed).
    task automatic run_job(input int ifa, input int ofa, input int c, input int h,
                           input int w, input int exp_lat);
        int n;
        int d0;
        int r0;
        d0 = done_cnt;
        r0 = req_cycles;
        @(negedge clk);
        mp_ifaddr = AW'(ifa);
        mp_ofaddr = AW'(ofa);
        mp_C      = 11'(c);
        mp_H      = 13'(h);
        mp_W      = 13'(w);
        mp_rst    = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                mp_rst    = 1'b0;
                mp_ifaddr = '1;
                mp_ofaddr = '1;
                mp_C      = '1;
                mp_H      = '1;
                mp_W      = '1;
            end
            #1;
        end while (done_cnt == d0 && n < 4000);
        if (done_cnt == d0) begin
            fail("done_timeout");
        end else begin
            if (exp_lat > 0) check("done_latency", n, exp_lat);
            if (exp_lat == 2) check("degenerate_no_traffic", req_cycles - r0, 0);
        end
        repeat (4) @(negedge clk);
        #1;
        check("single_done", done_cnt - d0, 1);
    endtask

    initial begin : stimulus
        int n;
        int r0;
        rst_n = 1'b0; mp_rst = 1'b0; mp_ifaddr = '0; mp_ofaddr = '0;
        mp_C = '0; mp_H = '0; mp_W = '0;
        repeat (3) @(negedge clk);
        check("rst_mp_done", longint'(mp_done), 0);
        check("rst_rd_req", longint'(rd_req), 0);
        check("rst_wr_req", longint'(wr_req), 0);
        check("rst_rd_addr", longint'(rd_addr), 0);
        check("rst_wr_addr", longint'(wr_addr), 0);
        check("rst_wr_data", longint'(wr_data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4x4 ramp: maxima are the bottom-right element of each window.
        for (int i = 0; i < 16; i++) ld(32'h100 + i, i);
        push(32'h200, 5); push(32'h201, 7); push(32'h202, 13); push(32'h203, 15);
        run_job(32'h100, 32'h200, 1, 4, 4, 38);

        // Odd H/W: only rows 0-1 and columns 0-3 of each plane exist in memory.
        mem.delete();
        ld(0, 4);   ld(1, 9);   ld(2, -2);  ld(3, 1);
        ld(5, 7);   ld(6, 3);   ld(7, 0);   ld(8, 6);
        ld(15, -7); ld(16, -9); ld(17, 12); ld(18, 11);
        ld(20, -8); ld(21, -6); ld(22, 11); ld(23, 12);
        push(0, 9); push(1, 6); push(2, -6); push(3, 12);
        run_job(0, 0, 2, 3, 5, 38);

        // Signed windows, including an all-equal window.
        mem.delete();
        ld(32'h300, -3); ld(32'h301, -1); ld(32'h302, -5); ld(32'h303, -5);
        ld(32'h304, -8); ld(32'h305, -2); ld(32'h306, -5); ld(32'h307, -5);
        push(32'h400, -1); push(32'h401, -5);
        run_job(32'h300, 32'h400, 1, 2, 4, 20);

        // Ramp again under random backpressure and read delay.
        mem.delete();
        for (int i = 0; i < 16; i++) ld(32'h100 + i, i);
        bp = 1'b1;
        push(32'h200, 5); push(32'h201, 7); push(32'h202, 13); push(32'h203, 15);
        run_job(32'h100, 32'h200, 1, 4, 4, 0);
        bp = 1'b0;

        // Degenerate shapes.
        run_job(32'h100, 32'h200, 0, 4, 4, 2);
        run_job(32'h100, 32'h200, 1, 1, 4, 2);

        // Abort after the 2nd read is accepted, before its data returns.
        ld(32'h500, -10); ld(32'h501, -20); ld(32'h502, -30); ld(32'h503, -7);
        fixed_delay = 3;
        r0 = rd_acc;
        @(negedge clk);
        mp_ifaddr = AW'(32'h100); mp_ofaddr = AW'(32'h700);
        mp_C = 11'd1; mp_H = 13'd4; mp_W = 13'd4;
        mp_rst = 1'b1;
        @(negedge clk);
        mp_rst = 1'b0;
        n = 0;
        while (rd_acc - r0 < 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rd_acc - r0 < 2) fail("abort_read_timeout");
        push(32'h600, -7);
        run_job(32'h500, 32'h600, 1, 2, 2, 0);
        fixed_delay = 0;

        repeat (10) @(negedge clk);
        #1;
        check("queue_empty", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
